// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC sequencer: state encoding and a sizing helper.
package sar_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_SAMPLE  = 3'd1;
  localparam logic [2:0] ENC_SETTLE  = 3'd2;
  localparam logic [2:0] ENC_COMPARE = 3'd3;
  localparam logic [2:0] ENC_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ENC_IDLE,
    SAMPLE  = ENC_SAMPLE,
    SETTLE  = ENC_SETTLE,
    COMPARE = ENC_COMPARE,
    DONE    = ENC_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for the asynchronous comparator output.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion sequencer: sample, then per bit settle the DAC and resolve the
// synchronized comparator decision, MSB first; result delivered with a valid pulse.
//
// state   | meaning
// IDLE    | waiting for start_i
// SAMPLE  | track/hold switch closed, trial code cleared
// SETTLE  | DAC driven with trial | (1<<idx), comparator off
// COMPARE | comparator enabled, decision taken on last cycle
// DONE    | result_o updated, valid_o pulses
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SAMPLE_CYC  = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CMP_INV     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  input  logic             comp_i,
  output logic             cmp_en_o,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o
);

  localparam int CNT_MAX = max3(SAMPLE_CYC, SETTLE_CYC, SYNC_STAGES + 1);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LD  = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] COMPARE_LD = CNT_W'(SYNC_STAGES);
  localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] trial, trial_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             sync_out;
  logic             decision;
  logic             cnt_tc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_i),
    .q     (sync_out)
  );

  assign decision = sync_out ^ (CMP_INV != 0);
  assign cnt_tc   = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= IDX_MSB;
      trial    <= '0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      trial    <= trial_nxt;
      result_q <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    trial_nxt  = trial;
    result_nxt = result_q;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = SAMPLE;
          cnt_nxt   = SAMPLE_LD;
          idx_nxt   = IDX_MSB;
          trial_nxt = '0;
        end
      end
      SAMPLE: begin
        trial_nxt = '0;
        if (cnt_tc) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_tc) begin
          state_nxt = COMPARE;
          cnt_nxt   = COMPARE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      COMPARE: begin
        if (cnt_tc) begin
          trial_nxt[idx] = decision;
          if (idx == '0) begin
            // result is published on entry to DONE so it is stable while valid_o is high
            state_nxt  = DONE;
            result_nxt = trial_nxt;
          end else begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LD;
            idx_nxt   = idx - IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        idx_nxt = IDX_MSB;
        if (cont_i) begin
          state_nxt = SAMPLE;
          cnt_nxt   = SAMPLE_LD;
          trial_nxt = '0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = IDX_MSB;
      end
    endcase

    // abort overrides every transition, including the final write of result_q
    if (abort_i && (state != IDLE)) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      idx_nxt    = IDX_MSB;
      trial_nxt  = '0;
      result_nxt = result_q;
    end
  end

  assign busy_o     = (state != IDLE);
  assign sample_o   = (state == SAMPLE);
  assign cmp_en_o   = (state == COMPARE);
  assign valid_o    = (state == DONE);
  assign dac_code_o = ((state == SETTLE) || (state == COMPARE)) ? (trial | (ONE << idx)) : '0;
  assign result_o   = result_q;

endmodule
